proc_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32I core.
- Owns the PC and the instruction register, and drives the instruction-memory fetch handshake.
- Feeds the latched instruction to the instruction decoder, then sequences execute, data-memory access and register writeback from the decoder's control outputs.
- Enters a sticky trap state on decode exceptions, misaligned targets or memory timeouts.

---
 rtl/proc_sequencer_pkg.sv | 25 ++
 rtl/proc_sequencer_if.sv | 23 ++
 rtl/proc_sequencer_timeout.sv | 27 ++
 rtl/proc_sequencer.sv | 156 +++++++++++++++
 tb/tb_proc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_sequencer_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: FSM states,
// destination data source codes and the reset NOP.
package proc_pkg;

    typedef enum logic [2:0] {
        SEQ_FETCH  = 3'd0,
        SEQ_DECODE = 3'd1,
        SEQ_EXEC   = 3'd2,
        SEQ_MEM    = 3'd3,
        SEQ_WB     = 3'd4,
        SEQ_TRAP   = 3'd5
    } seq_state_t;

    localparam logic [1:0] SRC_MEM  = 2'd0;
    localparam logic [1:0] SRC_FLOW = 2'd1;
    localparam logic [1:0] SRC_ALU  = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Instruction and data memory handshake bundle between the sequencer
// (master) and the memory subsystem (slave).
interface proc_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );

endinterface

// File: rtl/proc_sequencer_timeout.sv
// 8-bit memory wait counter; expired fires on the LIMIT-th consecutive
// waiting cycle so the sequencer can trap on that same edge.
module proc_seq_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = enable && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with a sticky TRAP state.
// Optional PROC_SEQ_PERF_EN adds cycle_count and retired_count outputs.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    proc_sequencer_if.master bus,
    output logic [31:0] instr,
    input  logic        dec_reg_write_enable,
    input  logic        dec_mem_write_enable,
    input  logic [1:0]  dec_dst_data_source,
    input  logic [4:0]  dec_rd,
    input  logic        dec_exception,
    input  logic [31:0] next_pc,
    output logic        rf_we,
    output logic [31:0] pc,
`ifdef PROC_SEQ_PERF_EN
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count,
`endif
    output logic [2:0]  state,
    output logic        halted
);

    seq_state_t state_q;
    logic       imem_req_q;
    logic       dmem_req_q;
    logic       dmem_we_q;
    logic       waiting;
    logic       clear_wait;
    logic       expired;
    logic       wr_strobe;

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_we_q;
    assign state         = state_q;

    assign wr_strobe  = dec_reg_write_enable && (dec_rd != 5'd0);
    assign waiting    = ((state_q == SEQ_FETCH) && imem_req_q && !bus.imem_ack) ||
                        ((state_q == SEQ_MEM)   && dmem_req_q && !bus.dmem_ack);
    // Holding the counter clear outside FETCH/MEM guarantees it starts at 0 on entry.
    assign clear_wait = !((state_q == SEQ_FETCH) || (state_q == SEQ_MEM));

    proc_seq_timeout #(.LIMIT(MEM_TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear_wait),
        .enable  (waiting),
        .expired (expired)
    );

    // rf_we is armed on entry to WB so it is high for exactly the WB cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ_FETCH;
            pc         <= RESET_PC;
            instr      <= NOP_INSTR;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we      <= 1'b0;
            halted     <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            case (state_q)
                SEQ_FETCH: begin
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (bus.imem_ack) begin
                        instr      <= bus.imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= SEQ_DECODE;
                    end else if (expired) begin
                        imem_req_q <= 1'b0;
                        halted     <= 1'b1;
                        state_q    <= SEQ_TRAP;
                    end
                end
                SEQ_DECODE: begin
                    if (dec_exception) begin
                        halted  <= 1'b1;
                        state_q <= SEQ_TRAP;
                    end else begin
                        state_q <= SEQ_EXEC;
                    end
                end
                SEQ_EXEC: begin
                    if ((dec_dst_data_source == SRC_MEM) || dec_mem_write_enable) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= dec_mem_write_enable;
                        state_q    <= SEQ_MEM;
                    end else begin
                        rf_we   <= wr_strobe;
                        state_q <= SEQ_WB;
                    end
                end
                SEQ_MEM: begin
                    if (bus.dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        rf_we      <= wr_strobe;
                        state_q    <= SEQ_WB;
                    end else if (expired) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        halted     <= 1'b1;
                        state_q    <= SEQ_TRAP;
                    end
                end
                SEQ_WB: begin
                    if (!is_word_aligned(next_pc)) begin
                        halted  <= 1'b1;
                        state_q <= SEQ_TRAP;
                    end else begin
                        pc         <= next_pc;
                        imem_req_q <= 1'b1;
                        state_q    <= SEQ_FETCH;
                    end
                end
                SEQ_TRAP: begin
                    state_q <= SEQ_TRAP;
                end
                default: begin
                    imem_req_q <= 1'b0;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                    halted     <= 1'b1;
                    state_q    <= SEQ_TRAP;
                end
            endcase
        end
    end

`ifdef PROC_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count   <= 32'd0;
            retired_count <= 32'd0;
        end else begin
            if (state_q != SEQ_TRAP) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if ((state_q == SEQ_WB) && is_word_aligned(next_pc)) begin
                retired_count <= retired_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: the bench plays both memory and decoder,
// with hand-computed expectations for each instruction scenario.
module tb_proc_sequencer;
    import proc_pkg::*;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          MEM_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr;
    logic        dec_reg_write_enable;
    logic        dec_mem_write_enable;
    logic [1:0]  dec_dst_data_source;
    logic [4:0]  dec_rd;
    logic        dec_exception;
    logic [31:0] next_pc;
    logic        rf_we;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        halted;
`ifdef PROC_SEQ_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] retired_count;
`endif

    int errors = 0;
    int checks = 0;
    int cycleNo = 0;
    int rfWeCount = 0;
    int dmemReqCount = 0;
    int imemReqCount = 0;
    int rfBase;
    int dmemBase;
    int imemBase;
    int startCycle;

    proc_sequencer_if bus();

    proc_sequencer #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bus                  (bus),
        .instr                (instr),
        .dec_reg_write_enable (dec_reg_write_enable),
        .dec_mem_write_enable (dec_mem_write_enable),
        .dec_dst_data_source  (dec_dst_data_source),
        .dec_rd               (dec_rd),
        .dec_exception        (dec_exception),
        .next_pc              (next_pc),
        .rf_we                (rf_we),
        .pc                   (pc),
`ifdef PROC_SEQ_PERF_EN
        .cycle_count          (cycle_count),
        .retired_count        (retired_count),
`endif
        .state                (state),
        .halted               (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Per-cycle occupancy of strobes and requests, sampled mid-cycle.
    always @(negedge clk) begin
        if (rf_we)        rfWeCount    <= rfWeCount + 1;
        if (bus.dmem_req) dmemReqCount <= dmemReqCount + 1;
        if (bus.imem_req) imemReqCount <= imemReqCount + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rwe, input logic mwe, input logic [1:0] src,
                                 input logic [4:0] rd, input logic exc,
                                 input logic [31:0] npc);
        dec_reg_write_enable = rwe;
        dec_mem_write_enable = mwe;
        dec_dst_data_source  = src;
        dec_rd               = rd;
        dec_exception        = exc;
        next_pc              = npc;
    endtask

    task automatic fetchWord(input logic [31:0] word);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        tick();
        bus.imem_ack   = 1'b0;
    endtask

    task automatic resetCore();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.dmem_ack   = 1'b0;
        applyStimulus(1'b0, 1'b0, SRC_NONE, 5'd0, 1'b0, 32'h0);

        tick();
        tick();
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_instr", instr, 32'h0000_0013);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
        checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);

        rst_n = 1'b1;
        tick();
        checkOutput("fetch_req_start", 32'(bus.imem_req), 32'd1);

        // addi x1,x0,5 with a one-cycle late imem ack
        tick();
        checkOutput("addi_wait_state", 32'(state), 32'd0);
        rfBase = rfWeCount;
        fetchWord(32'h0050_0093);
        checkOutput("addi_instr", instr, 32'h0050_0093);
        checkOutput("addi_decode", 32'(state), 32'd1);
        checkOutput("addi_req_drop", 32'(bus.imem_req), 32'd0);
        applyStimulus(1'b1, 1'b0, SRC_ALU, 5'd1, 1'b0, 32'h4);
        tick();
        checkOutput("addi_exec", 32'(state), 32'd2);
        tick();
        checkOutput("addi_wb", 32'(state), 32'd4);
        checkOutput("addi_rf_we", 32'(rf_we), 32'd1);
        checkOutput("addi_pc_wb", pc, 32'h0);
        tick();
        checkOutput("addi_fetch", 32'(state), 32'd0);
        checkOutput("addi_pc", pc, 32'h4);
        checkOutput("addi_imem_addr", bus.imem_addr, 32'h4);
        checkOutput("addi_req_again", 32'(bus.imem_req), 32'd1);
        checkOutput("addi_rf_pulses", 32'(rfWeCount - rfBase), 32'd1);

        // lw x2,0(x1): zero-wait fetch, dmem ack on the 4th MEM cycle
        startCycle = cycleNo;
        dmemBase   = dmemReqCount;
        rfBase     = rfWeCount;
        fetchWord(32'h0000_A103);
        applyStimulus(1'b1, 1'b0, SRC_MEM, 5'd2, 1'b0, 32'h8);
        tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.imem_ack   = 1'b0;
        checkOutput("lw_instr_kept", instr, 32'h0000_A103);
        checkOutput("lw_mem_state", 32'(state), 32'd3);
        checkOutput("lw_dmem_req", 32'(bus.dmem_req), 32'd1);
        checkOutput("lw_dmem_we", 32'(bus.dmem_we), 32'd0);
        tick();
        tick();
        tick();
        checkOutput("lw_still_wait", 32'(bus.dmem_req), 32'd1);
        checkOutput("lw_no_early_rf", 32'(rf_we), 32'd0);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        checkOutput("lw_wb_rf_we", 32'(rf_we), 32'd1);
        checkOutput("lw_req_drop", 32'(bus.dmem_req), 32'd0);
        checkOutput("lw_req_cycles", 32'(dmemReqCount - dmemBase), 32'd4);
        tick();
        checkOutput("lw_pc", pc, 32'h8);
        checkOutput("lw_fetch_to_fetch", 32'(cycleNo - startCycle), 32'd8);
        checkOutput("lw_rf_pulses", 32'(rfWeCount - rfBase), 32'd1);

        // sw x2,0(x1) with same-cycle dmem ack
        rfBase = rfWeCount;
        fetchWord(32'h0020_A023);
        applyStimulus(1'b0, 1'b1, SRC_NONE, 5'd0, 1'b0, 32'hC);
        tick();
        tick();
        checkOutput("sw_dmem_req", 32'(bus.dmem_req), 32'd1);
        checkOutput("sw_dmem_we", 32'(bus.dmem_we), 32'd1);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        checkOutput("sw_wb", 32'(state), 32'd4);
        checkOutput("sw_rf_we", 32'(rf_we), 32'd0);
        tick();
        checkOutput("sw_pc", pc, 32'hC);
        checkOutput("sw_rf_pulses", 32'(rfWeCount - rfBase), 32'd0);

        // load whose dmem ack never arrives
        fetchWord(32'h0000_A103);
        applyStimulus(1'b1, 1'b0, SRC_MEM, 5'd2, 1'b0, 32'h10);
        tick();
        tick();
        repeat (7) tick();
        checkOutput("to_last_wait_state", 32'(state), 32'd3);
        checkOutput("to_last_wait_req", 32'(bus.dmem_req), 32'd1);
        tick();
        checkOutput("to_trap_state", 32'(state), 32'd5);
        checkOutput("to_trap_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("to_halted", 32'(halted), 32'd1);
        checkOutput("to_pc_held", pc, 32'hC);
        tick();
        tick();
        checkOutput("to_req_stays_low", 32'(bus.dmem_req), 32'd0);

        // misaligned flow target traps from WB after the write strobe
        resetCore();
        fetchWord(32'h0050_0093);
        applyStimulus(1'b1, 1'b0, SRC_ALU, 5'd1, 1'b0, 32'h6);
        rfBase = rfWeCount;
        tick();
        tick();
        checkOutput("mis_wb_rf_we", 32'(rf_we), 32'd1);
        tick();
        checkOutput("mis_trap_state", 32'(state), 32'd5);
        checkOutput("mis_pc_held", pc, 32'h0);
        checkOutput("mis_halted", 32'(halted), 32'd1);
        checkOutput("mis_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("mis_rf_pulses", 32'(rfWeCount - rfBase), 32'd1);

        // FENCE reported as a decode exception; acks during TRAP are ignored
        resetCore();
        rfBase = rfWeCount;
        fetchWord(32'h0000_000F);
        applyStimulus(1'b0, 1'b0, SRC_NONE, 5'd0, 1'b1, 32'h4);
        tick();
        checkOutput("fence_trap_state", 32'(state), 32'd5);
        checkOutput("fence_halted", 32'(halted), 32'd1);
        imemBase = imemReqCount;
        for (int i = 0; i < 100; i++) begin
            bus.imem_ack = i[0];
            bus.dmem_ack = ~i[0];
            tick();
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        checkOutput("fence_no_fetch", 32'(imemReqCount - imemBase), 32'd0);
        checkOutput("fence_no_rf_we", 32'(rfWeCount - rfBase), 32'd0);
        checkOutput("fence_state_sticky", 32'(state), 32'd5);
        checkOutput("fence_pc", pc, 32'h0);

        // reset asserted while a load waits in MEM
        resetCore();
        fetchWord(32'h0000_A103);
        applyStimulus(1'b1, 1'b0, SRC_MEM, 5'd2, 1'b0, 32'h4);
        rfBase = rfWeCount;
        tick();
        tick();
        checkOutput("mm_dmem_req", 32'(bus.dmem_req), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("mm_async_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("mm_async_pc", pc, RESET_PC);
        checkOutput("mm_async_state", 32'(state), 32'd0);
        checkOutput("mm_async_instr", instr, 32'h0000_0013);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("mm_restart_req", 32'(bus.imem_req), 32'd1);
        checkOutput("mm_no_rf_we", 32'(rfWeCount - rfBase), 32'd0);
        fetchWord(32'h0050_0093);
        applyStimulus(1'b1, 1'b0, SRC_ALU, 5'd1, 1'b0, 32'h4);
        tick();
        tick();
        tick();
        checkOutput("mm_clean_pc", pc, 32'h4);
        checkOutput("mm_clean_rf", 32'(rfWeCount - rfBase), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
